// File: rtl/stack_ram_responder.sv
// -----------------------------------------------------------------------------
// stack_ram_responder
//
// Memory-side responder for the stack-calculator controller. Owns a
// 2**ADDR_W x DATA_W data RAM and a downward-growing stack pointer, and serves
// one command at a time over a valid/ready request channel. Every accepted
// request produces exactly one single-cycle response strobe.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only while idle and out of reset.
// There is no response backpressure: rsp_valid is a one-cycle strobe and
// rsp_data/rsp_err hold their value until the next strobe.
//
// Timing: accept at edge k, execute (RAM access, sp update, response
// registered) at edge k+1, rsp_valid high between k+1 and k+2, idle at k+2.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_cmd               0 NOP,1 PUSH,2 POP,3 PEEK,4 READ,5 WRITE,6 CLEAR,7 PEEK2
//   req_addr, req_wdata   address (READ/WRITE) and data (PUSH/WRITE)
//   rsp_valid             one-cycle response strobe
//   rsp_data, rsp_err     response payload, held between strobes
//   sp, depth             stack pointer (next free slot), entry count
//   stack_empty/full      status flags derived from sp (registered)
// -----------------------------------------------------------------------------
module stack_ram_responder #(
   parameter int                ADDR_W  = 7,
   parameter int                DATA_W  = 8,
   parameter logic [ADDR_W-1:0] SP_INIT = 7'h7F
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_cmd,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] sp,
   output logic [ADDR_W-1:0] depth,
   output logic              stack_empty,
   output logic              stack_full
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [2:0] CMD_NOP   = 3'd0;
   localparam logic [2:0] CMD_PUSH  = 3'd1;
   localparam logic [2:0] CMD_POP   = 3'd2;
   localparam logic [2:0] CMD_PEEK  = 3'd3;
   localparam logic [2:0] CMD_READ  = 3'd4;
   localparam logic [2:0] CMD_WRITE = 3'd5;
   localparam logic [2:0] CMD_CLEAR = 3'd6;
   localparam logic [2:0] CMD_PEEK2 = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state;

   logic [DATA_W-1:0] mem [DEPTH];

   // Command latched at the handshake edge
   logic [2:0]        cmd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   // Execute-stage decode, only meaningful while state == ST_EXEC
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] sp_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              err_nxt;

   // Combinational so that a request is refused in the same cycle rst_n drops.
   assign req_ready = (state == ST_IDLE) && rst_n;

   assign rd_data = mem[rd_addr];

   // Pointer math wraps modulo 2**ADDR_W; the error checks keep sp in range.
   always_comb begin
      rd_addr  = addr_q;
      wr_en    = 1'b0;
      wr_addr  = addr_q;
      sp_nxt   = sp;
      data_nxt = '0;
      err_nxt  = 1'b0;
      unique case (cmd_q)
         CMD_NOP: begin
         end
         CMD_PUSH: begin
            if (stack_full) begin
               err_nxt = 1'b1;
            end else begin
               wr_en    = 1'b1;
               wr_addr  = sp;
               sp_nxt   = sp - 1'b1;
               data_nxt = wdata_q;
            end
         end
         CMD_POP: begin
            rd_addr = sp + 1'b1;
            if (stack_empty) begin
               err_nxt = 1'b1;
            end else begin
               sp_nxt   = sp + 1'b1;
               data_nxt = rd_data;
            end
         end
         CMD_PEEK: begin
            rd_addr = sp + 1'b1;
            if (stack_empty) err_nxt  = 1'b1;
            else             data_nxt = rd_data;
         end
         CMD_READ: begin
            data_nxt = rd_data;
         end
         CMD_WRITE: begin
            wr_en    = 1'b1;
            data_nxt = wdata_q;
         end
         CMD_CLEAR: begin
            sp_nxt = SP_INIT;
         end
         CMD_PEEK2: begin
            rd_addr = sp + 2'd2;
            if (depth < 2) err_nxt  = 1'b1;
            else           data_nxt = rd_data;
         end
         default: begin
         end
      endcase
   end

   // RAM has no reset; writes are suppressed while rst_n is low.
   always_ff @(posedge clk) begin
      if (rst_n && (state == ST_EXEC) && wr_en) begin
         mem[wr_addr] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cmd_q       <= CMD_NOP;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         sp          <= SP_INIT;
         depth       <= '0;
         stack_empty <= 1'b1;
         stack_full  <= (SP_INIT == '0);
      end else begin
         unique case (state)
            ST_IDLE: begin
               rsp_valid <= 1'b0;
               if (req_valid) begin
                  cmd_q   <= req_cmd;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  state   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_valid   <= 1'b1;
               rsp_data    <= data_nxt;
               rsp_err     <= err_nxt;
               sp          <= sp_nxt;
               depth       <= SP_INIT - sp_nxt;
               stack_empty <= (sp_nxt == SP_INIT);
               stack_full  <= (sp_nxt == '0);
               state       <= ST_RESP;
            end
            ST_RESP: begin
               rsp_valid <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ram_responder.sv
module tb_stack_ram_responder;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_cmd;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic [6:0] sp;
   logic [6:0] depth;
   logic       stack_empty;
   logic       stack_full;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, PEEK = 3'd3,
                          READ = 3'd4, WRITE = 3'd5, CLEAR = 3'd6, PEEK2 = 3'd7;

   stack_ram_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cmd    (req_cmd),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .sp         (sp),
      .depth      (depth),
      .stack_empty(stack_empty),
      .stack_full (stack_full)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one command starting at a negedge with the DUT idle; returns at the
   // negedge after the response strobe, DUT idle again. Inputs are scrambled
   // after the handshake edge to show they are ignored.
   task automatic do_cmd(input string tag, input logic [2:0] c, input logic [6:0] a,
                         input logic [7:0] w, input logic [7:0] ed, input logic ee);
      check({tag, ".ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_cmd   = c;
      req_addr  = a;
      req_wdata = w;
      @(negedge clk);
      req_valid = 1'b0;
      req_cmd   = 3'($urandom_range(0, 7));
      req_addr  = 7'($urandom_range(0, 127));
      req_wdata = 8'($urandom_range(0, 255));
      check({tag, ".exec_valid"}, rsp_valid, 0);
      check({tag, ".exec_ready"}, req_ready, 0);
      @(negedge clk);
      check({tag, ".rsp_valid"}, rsp_valid, 1);
      check({tag, ".rsp_data"}, rsp_data, ed);
      check({tag, ".rsp_err"}, rsp_err, ee);
      @(negedge clk);
      check({tag, ".valid_low"}, rsp_valid, 0);
      check({tag, ".data_hold"}, rsp_data, ed);
      check({tag, ".err_hold"}, rsp_err, ee);
   endtask

   task automatic check_status(input string tag, input logic [6:0] esp);
      check({tag, ".sp"}, sp, esp);
      check({tag, ".depth"}, depth, 7'h7F - esp);
      check({tag, ".empty"}, stack_empty, esp == 7'h7F);
      check({tag, ".full"}, stack_full, esp == 7'h00);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_cmd   = NOP;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);

      // reset state, and a request offered during reset is refused
      check("rst.ready", req_ready, 0);
      check("rst.rsp_valid", rsp_valid, 0);
      check("rst.rsp_data", rsp_data, 0);
      check("rst.rsp_err", rsp_err, 0);
      check_status("rst", 7'h7F);
      req_valid = 1'b1;
      req_cmd   = PUSH;
      req_wdata = 8'hEE;
      repeat (2) @(negedge clk);
      check("rst_req.rsp_valid", rsp_valid, 0);
      check_status("rst_req", 7'h7F);
      req_valid = 1'b0;
      rst_n     = 1'b1;
      #1;
      check("rel.ready", req_ready, 1);
      @(negedge clk);

      // basic push / peek / pop
      do_cmd("nop", NOP, 7'h00, 8'h00, 8'h00, 1'b0);
      do_cmd("push05", PUSH, 7'h00, 8'h05, 8'h05, 1'b0);
      check_status("push05", 7'h7E);
      do_cmd("push0a", PUSH, 7'h00, 8'h0A, 8'h0A, 1'b0);
      check_status("push0a", 7'h7D);
      do_cmd("peek2", PEEK2, 7'h00, 8'h00, 8'h05, 1'b0);
      do_cmd("peek", PEEK, 7'h00, 8'h00, 8'h0A, 1'b0);
      check_status("peek", 7'h7D);
      do_cmd("pop0a", POP, 7'h00, 8'h00, 8'h0A, 1'b0);
      do_cmd("peek2_d1", PEEK2, 7'h00, 8'h00, 8'h00, 1'b1);
      do_cmd("pop05", POP, 7'h00, 8'h00, 8'h05, 1'b0);
      do_cmd("pop_empty", POP, 7'h00, 8'h00, 8'h00, 1'b1);
      check_status("pop_empty", 7'h7F);
      do_cmd("peek_empty", PEEK, 7'h00, 8'h00, 8'h00, 1'b1);

      // fill the stack; slot 0 must survive the overflowing push
      do_cmd("wr0", WRITE, 7'h00, 8'hA5, 8'hA5, 1'b0);
      for (int i = 1; i <= 127; i++) begin
         do_cmd($sformatf("fill%0d", i), PUSH, 7'h00, 8'(i), 8'(i), 1'b0);
      end
      check_status("full", 7'h00);
      do_cmd("push_full", PUSH, 7'h00, 8'hEE, 8'h00, 1'b1);
      check_status("push_full", 7'h00);
      do_cmd("rd0", READ, 7'h00, 8'h00, 8'hA5, 1'b0);
      do_cmd("peek_full", PEEK, 7'h00, 8'h00, 8'h7F, 1'b0);
      do_cmd("peek2_full", PEEK2, 7'h00, 8'h00, 8'h7E, 1'b0);
      do_cmd("clr_full", CLEAR, 7'h00, 8'h00, 8'h00, 1'b0);
      check_status("clr_full", 7'h7F);

      // WRITE into a live slot then POP it
      do_cmd("push11", PUSH, 7'h00, 8'h11, 8'h11, 1'b0);
      do_cmd("push22", PUSH, 7'h00, 8'h22, 8'h22, 1'b0);
      do_cmd("wr7e", WRITE, 7'h7E, 8'h33, 8'h33, 1'b0);
      check_status("wr7e", 7'h7D);
      do_cmd("pop33", POP, 7'h00, 8'h00, 8'h33, 1'b0);
      check_status("pop33", 7'h7E);
      do_cmd("rd7e", READ, 7'h7E, 8'h00, 8'h33, 1'b0);
      check_status("rd7e", 7'h7E);

      // CLEAR leaves RAM untouched
      do_cmd("push44", PUSH, 7'h00, 8'h44, 8'h44, 1'b0);
      do_cmd("push55", PUSH, 7'h00, 8'h55, 8'h55, 1'b0);
      check_status("d3", 7'h7C);
      do_cmd("clear", CLEAR, 7'h00, 8'h00, 8'h00, 1'b0);
      check_status("clear", 7'h7F);
      do_cmd("rd7f", READ, 7'h7F, 8'h00, 8'h11, 1'b0);
      do_cmd("rd7e_c", READ, 7'h7E, 8'h00, 8'h44, 1'b0);
      do_cmd("rd7d", READ, 7'h7D, 8'h00, 8'h55, 1'b0);

      // reset on the EXEC edge of a PUSH aborts it
      check("abort.ready", req_ready, 1);
      req_valid = 1'b1;
      req_cmd   = PUSH;
      req_wdata = 8'h99;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      check("abort.rsp_valid", rsp_valid, 0);
      check("abort.ready_rst", req_ready, 0);
      check_status("abort", 7'h7F);
      rst_n = 1'b1;
      #1;
      check("abort.ready_rel", req_ready, 1);
      @(negedge clk);
      check("abort.rsp_valid2", rsp_valid, 0);
      check_status("abort2", 7'h7F);
      do_cmd("rd7f_abort", READ, 7'h7F, 8'h00, 8'h11, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
